// File: rtl/afifo_pkg.sv
// Shared sizing helpers for the afifo read/write side blocks.
// Width ratio between FIFO word and stream beat, and the matching slice-index width.
package afifo_pkg;

  function automatic int ratio(input int dw, input int ow);
    return dw / ow;
  endfunction

  // A 1-bit index is kept even when R=1 so the slicer needs no special case.
  function automatic int idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/afifo_rd_stream.sv
// Read-side consumer of afifo: pops DW-bit words and replays them as R=DW/OW
// registered valid/ready beats, LSB slice first, with m_last on the final slice.
module afifo_rd_stream
  import afifo_pkg::*;
#(
  parameter int DW = 128,
  parameter int OW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          rempty,
  input  logic [DW-1:0] q,
  output logic          re,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          m_last,
  output logic          busy,
  output logic [CW-1:0] pop_cnt
);

  localparam int R    = ratio(DW, OW);
  localparam int IDXW = idx_width(R);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(R - 1);

  logic [DW-1:0]   wbuf_q, wbuf_d;
  logic            wvalid_q, wvalid_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            m_valid_q, m_valid_d;
  logic [OW-1:0]   m_data_q, m_data_d;
  logic            m_last_q, m_last_d;
  logic [CW-1:0]   pop_cnt_q, pop_cnt_d;
  logic            adv;
  logic            last_mv;

  always_comb begin
    adv     = !m_valid_q || m_ready;
    last_mv = adv && wvalid_q && (idx_q == LAST_IDX);
    // Refill in the same cycle the last slice leaves so words stream without a gap.
    re      = !reset && !rempty && (!wvalid_q || last_mv);

    wbuf_d    = wbuf_q;
    wvalid_d  = wvalid_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_last_d  = m_last_q;
    pop_cnt_d = pop_cnt_q;

    if (re) begin
      wbuf_d    = q;
      wvalid_d  = 1'b1;
      pop_cnt_d = pop_cnt_q + CW'(1);
    end else if (last_mv) begin
      wvalid_d = 1'b0;
    end

    if (adv && wvalid_q) begin
      m_data_d  = wbuf_q[int'(idx_q) * OW +: OW];
      m_last_d  = (idx_q == LAST_IDX);
      m_valid_d = 1'b1;
      idx_d     = (R == 1) ? '0 : idx_q + IDXW'(1);
    end else if (adv) begin
      m_valid_d = 1'b0;
    end
  end

  // wbuf is only meaningful under wvalid, so it is left out of reset.
  always_ff @(posedge clk) begin
    wbuf_q <= wbuf_d;
    if (reset) begin
      wvalid_q  <= 1'b0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_last_q  <= 1'b0;
      pop_cnt_q <= '0;
    end else begin
      wvalid_q  <= wvalid_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_last_q  <= m_last_d;
      pop_cnt_q <= pop_cnt_d;
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_last  = m_last_q;
  assign busy    = wvalid_q || m_valid_q;
  assign pop_cnt = pop_cnt_q;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: DUT A (DW=32, OW=8, CW=16) and DUT B (DW=OW=32, CW=4)
// fed from queue-modelled FIFOs; expected beats are queued when words are pushed.
module tb_afifo_rd_stream;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        rempty_a, re_a, m_valid_a, m_ready_a, m_last_a, busy_a;
  logic [31:0] q_a;
  logic [7:0]  m_data_a;
  logic [15:0] pop_cnt_a;
  logic        rempty_b, re_b, m_valid_b, m_ready_b, m_last_b, busy_b;
  logic [31:0] q_b, m_data_b;
  logic [3:0]  pop_cnt_b;

  afifo_rd_stream #(.DW(32), .OW(8), .CW(16)) dut_a (
    .clk(clk), .reset(reset), .rempty(rempty_a), .q(q_a), .re(re_a),
    .m_valid(m_valid_a), .m_ready(m_ready_a), .m_data(m_data_a),
    .m_last(m_last_a), .busy(busy_a), .pop_cnt(pop_cnt_a));

  afifo_rd_stream #(.DW(32), .OW(32), .CW(4)) dut_b (
    .clk(clk), .reset(reset), .rempty(rempty_b), .q(q_b), .re(re_b),
    .m_valid(m_valid_b), .m_ready(m_ready_b), .m_data(m_data_b),
    .m_last(m_last_b), .busy(busy_b), .pop_cnt(pop_cnt_b));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [31:0] fifo_a[$];
  beat_t       sb_a[$];
  logic [31:0] fifo_b[$];
  logic [31:0] sb_b[$];

  logic       s_re_a, s_mv_a, s_xfer_a;
  logic [7:0] s_data_a;
  int         s_cyc;
  int         xfer_n_a, xfer_first_a, xfer_last_a, re_cnt_a, exp_cnt_a;
  logic       hold_pend_a, hold_l_a;
  logic [7:0] hold_d_a;
  int         xfer_n_b, xfer_first_b, xfer_last_b, exp_cnt_b;

  task automatic refresh_a();
    rempty_a = (fifo_a.size() == 0);
    q_a      = (fifo_a.size() != 0) ? fifo_a[0] : 32'h0;
  endtask

  task automatic refresh_b();
    rempty_b = (fifo_b.size() == 0);
    q_b      = (fifo_b.size() != 0) ? fifo_b[0] : 32'h0;
  endtask

  task automatic push_a(input logic [31:0] w);
    beat_t b;
    fifo_a.push_back(w);
    for (int i = 0; i < 4; i++) begin
      b.d = w[i*8 +: 8];
      b.l = (i == 3);
      sb_a.push_back(b);
    end
    exp_cnt_a++;
    refresh_a();
  endtask

  task automatic push_b(input logic [31:0] w);
    fifo_b.push_back(w);
    sb_b.push_back(w);
    exp_cnt_b++;
    refresh_b();
  endtask

  // One clock of DUT A: sample at negedge, score any transfer, model the FIFO pop.
  task automatic step_a();
    beat_t e;
    logic  pop;
    @(negedge clk);
    s_cyc = cyc;
    s_re_a = re_a;
    s_mv_a = m_valid_a;
    s_data_a = m_data_a;
    s_xfer_a = m_valid_a && m_ready_a;
    n_cmp++;
    if (rempty_a && re_a) begin
      n_bad++;
      $display("FAIL re_while_empty: re=%b required 0", re_a);
    end
    if (hold_pend_a) begin
      n_cmp++;
      if (m_valid_a !== 1'b1 || m_data_a !== hold_d_a || m_last_a !== hold_l_a) begin
        n_bad++;
        $display("FAIL stall_hold: valid=%b data=%h last=%b required 1/%h/%b",
                 m_valid_a, m_data_a, m_last_a, hold_d_a, hold_l_a);
      end
    end
    hold_pend_a = m_valid_a && !m_ready_a;
    hold_d_a    = m_data_a;
    hold_l_a    = m_last_a;
    if (s_xfer_a) begin
      n_cmp++;
      if (sb_a.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat_a: data=%h required none", m_data_a);
      end else begin
        e = sb_a.pop_front();
        if (m_data_a !== e.d || m_last_a !== e.l) begin
          n_bad++;
          $display("FAIL beat_a: data=%h last=%b required %h/%b", m_data_a, m_last_a, e.d, e.l);
        end
      end
      if (xfer_n_a == 0) xfer_first_a = cyc;
      xfer_last_a = cyc;
      xfer_n_a++;
    end
    pop = re_a;
    if (re_a) re_cnt_a++;
    @(posedge clk);
    cyc++;
    #1;
    if (pop && fifo_a.size() != 0) void'(fifo_a.pop_front());
    refresh_a();
  endtask

  task automatic step_b();
    logic [31:0] e;
    logic        pop;
    @(negedge clk);
    n_cmp++;
    if (rempty_b && re_b) begin
      n_bad++;
      $display("FAIL re_while_empty_b: re=%b required 0", re_b);
    end
    if (m_valid_b && m_ready_b) begin
      n_cmp++;
      if (sb_b.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_beat_b: data=%h required none", m_data_b);
      end else begin
        e = sb_b.pop_front();
        if (m_data_b !== e || m_last_b !== 1'b1) begin
          n_bad++;
          $display("FAIL beat_b: data=%h last=%b required %h/1", m_data_b, m_last_b, e);
        end
      end
      if (xfer_n_b == 0) xfer_first_b = cyc;
      xfer_last_b = cyc;
      xfer_n_b++;
    end
    pop = re_b;
    @(posedge clk);
    cyc++;
    #1;
    if (pop && fifo_b.size() != 0) void'(fifo_b.pop_front());
    refresh_b();
  endtask

  task automatic drain_a(input int bound);
    int k = 0;
    while (sb_a.size() != 0 && k < bound) begin
      step_a();
      k++;
    end
    n_cmp++;
    if (sb_a.size() != 0) begin
      n_bad++;
      $display("FAIL drain_a_timeout: %0d beats left required 0", sb_a.size());
    end
  endtask

  task automatic drain_b(input int bound);
    int k = 0;
    while (sb_b.size() != 0 && k < bound) begin
      step_b();
      k++;
    end
    n_cmp++;
    if (sb_b.size() != 0) begin
      n_bad++;
      $display("FAIL drain_b_timeout: %0d beats left required 0", sb_b.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    m_ready_a = 1'b1;
    @(posedge clk);
    cyc++;
    #1;
    exp_cnt_a = 0;
    push_a(32'hDDCCBBAA);
    repeat (3) begin
      @(negedge clk);
      n_cmp += 2;
      if (re_a !== 1'b0) begin n_bad++; $display("FAIL reset_re: got %b want 0", re_a); end
      if (m_valid_a !== 1'b0) begin n_bad++; $display("FAIL reset_mvalid: got %b want 0", m_valid_a); end
      @(posedge clk);
      cyc++;
      #1;
    end
    n_cmp += 4;
    if (pop_cnt_a !== 16'd0) begin n_bad++; $display("FAIL reset_pop_cnt: got %0d want 0", pop_cnt_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    if (m_data_a !== 8'h00) begin n_bad++; $display("FAIL reset_mdata: got %h want 00", m_data_a); end
    if (m_last_a !== 1'b0) begin n_bad++; $display("FAIL reset_mlast: got %b want 0", m_last_a); end
    reset = 1'b0;
    re_cnt_a = 0;
    xfer_n_a = 0;
    step_a();
    n_cmp += 2;
    if (s_re_a !== 1'b1) begin n_bad++; $display("FAIL lat_re_c0: got %b want 1", s_re_a); end
    if (s_mv_a !== 1'b0) begin n_bad++; $display("FAIL lat_mv_c0: got %b want 0", s_mv_a); end
    step_a();
    n_cmp++;
    if (s_mv_a !== 1'b0) begin n_bad++; $display("FAIL lat_mv_c1: got %b want 0", s_mv_a); end
    step_a();
    n_cmp += 2;
    if (s_mv_a !== 1'b1) begin n_bad++; $display("FAIL lat_mv_c2: got %b want 1", s_mv_a); end
    if (s_data_a !== 8'hAA) begin n_bad++; $display("FAIL lat_data_c2: got %h want aa", s_data_a); end
  endtask

  task automatic test_single_word();
    drain_a(10);
    n_cmp += 5;
    if (re_cnt_a != 1) begin n_bad++; $display("FAIL single_re_count: got %0d want 1", re_cnt_a); end
    if (xfer_n_a != 4) begin n_bad++; $display("FAIL single_beats: got %0d want 4", xfer_n_a); end
    if (xfer_last_a - xfer_first_a != 3) begin
      n_bad++; $display("FAIL single_span: got %0d want 3", xfer_last_a - xfer_first_a);
    end
    if (pop_cnt_a !== 16'd1) begin n_bad++; $display("FAIL single_pop_cnt: got %0d want 1", pop_cnt_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL single_idle_busy: got %b want 0", busy_a); end
  endtask

  task automatic test_back_to_back();
    int re_cycs[$];
    int c03 = -100;
    int k = 0;
    xfer_n_a = 0;
    push_a(32'h03020100);
    push_a(32'h07060504);
    while (sb_a.size() != 0 && k < 40) begin
      step_a();
      if (s_re_a) re_cycs.push_back(s_cyc);
      if (s_xfer_a && s_data_a == 8'h03) c03 = s_cyc;
      k++;
    end
    n_cmp += 5;
    if (sb_a.size() != 0) begin n_bad++; $display("FAIL b2b_timeout: %0d left want 0", sb_a.size()); end
    if (xfer_n_a != 8) begin n_bad++; $display("FAIL b2b_beats: got %0d want 8", xfer_n_a); end
    if (xfer_last_a - xfer_first_a != 7) begin
      n_bad++; $display("FAIL b2b_bubble: span %0d want 7", xfer_last_a - xfer_first_a);
    end
    if (re_cycs.size() != 2) begin
      n_bad++; $display("FAIL b2b_re_count: got %0d want 2", re_cycs.size());
    end else if (re_cycs[1] != c03 - 1) begin
      n_bad++; $display("FAIL b2b_re_align: re at %0d want %0d", re_cycs[1], c03 - 1);
    end
    if (pop_cnt_a !== exp_cnt_a[15:0]) begin
      n_bad++; $display("FAIL b2b_pop_cnt: got %0d want %0d", pop_cnt_a, exp_cnt_a);
    end
  endtask

  task automatic test_backpressure();
    int k = 0;
    push_a(32'hDDCCBBAA);
    push_a(32'h44332211);
    while (!(m_valid_a === 1'b1 && m_data_a === 8'hBB) && k < 20) begin
      step_a();
      k++;
    end
    n_cmp++;
    if (k >= 20) begin n_bad++; $display("FAIL bp_find_bb: timeout, data=%h want bb", m_data_a); end
    m_ready_a = 1'b0;
    repeat (5) begin
      step_a();
      n_cmp += 3;
      if (s_mv_a !== 1'b1) begin n_bad++; $display("FAIL bp_valid: got %b want 1", s_mv_a); end
      if (s_data_a !== 8'hBB) begin n_bad++; $display("FAIL bp_data: got %h want bb", s_data_a); end
      if (s_re_a !== 1'b0) begin n_bad++; $display("FAIL bp_re: got %b want 0", s_re_a); end
    end
    m_ready_a = 1'b1;
    step_a();
    step_a();
    n_cmp++;
    if (s_data_a !== 8'hCC) begin n_bad++; $display("FAIL bp_resume: got %h want cc", s_data_a); end
    drain_a(20);
    n_cmp++;
    if (pop_cnt_a !== exp_cnt_a[15:0]) begin
      n_bad++; $display("FAIL bp_pop_cnt: got %0d want %0d", pop_cnt_a, exp_cnt_a);
    end
  endtask

  task automatic test_reset_mid_word();
    int k = 0;
    xfer_n_a = 0;
    push_a(32'hDDCCBBAA);
    while (xfer_n_a < 2 && k < 20) begin
      step_a();
      k++;
    end
    n_cmp++;
    if (xfer_n_a != 2) begin n_bad++; $display("FAIL rst_mid_setup: beats %0d want 2", xfer_n_a); end
    reset = 1'b1;
    m_ready_a = 1'b0;
    step_a();
    hold_pend_a = 1'b0;
    n_cmp += 3;
    if (m_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", m_valid_a); end
    if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy_a); end
    if (pop_cnt_a !== 16'd0) begin n_bad++; $display("FAIL rst_mid_pop_cnt: got %0d want 0", pop_cnt_a); end
    sb_a.delete();
    fifo_a.delete();
    refresh_a();
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    reset = 1'b0;
    m_ready_a = 1'b1;
    repeat (6) begin
      step_a();
      n_cmp++;
      if (s_mv_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stale_beat: data=%h valid=%b want 0", s_data_a, s_mv_a); end
    end
  endtask

  task automatic test_r1_stream();
    xfer_n_b = 0;
    for (int i = 0; i < 10; i++) push_b(32'hA5000000 + i * 32'h00010203);
    drain_b(30);
    n_cmp += 3;
    if (xfer_n_b != 10) begin n_bad++; $display("FAIL r1_words: got %0d want 10", xfer_n_b); end
    if (xfer_last_b - xfer_first_b != 9) begin
      n_bad++; $display("FAIL r1_span: got %0d want 9", xfer_last_b - xfer_first_b);
    end
    if (pop_cnt_b !== 4'd10) begin n_bad++; $display("FAIL r1_pop_cnt: got %0d want 10", pop_cnt_b); end
  endtask

  task automatic test_pop_cnt_wrap();
    for (int i = 0; i < 7; i++) push_b(32'h5A5A0000 + i);
    drain_b(30);
    step_b();
    n_cmp += 2;
    if (pop_cnt_b !== 4'd1) begin n_bad++; $display("FAIL wrap_pop_cnt: got %0d want 1", pop_cnt_b); end
    if (pop_cnt_b !== 4'(exp_cnt_b % 16)) begin
      n_bad++; $display("FAIL wrap_model: got %0d want %0d", pop_cnt_b, exp_cnt_b % 16);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    m_ready_a = 1'b1;
    m_ready_b = 1'b1;
    exp_cnt_a = 0;
    exp_cnt_b = 0;
    xfer_n_a = 0;
    xfer_n_b = 0;
    re_cnt_a = 0;
    hold_pend_a = 1'b0;
    refresh_a();
    refresh_b();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_word();
    test_r1_stream();
    test_pop_cnt_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
